// File: rtl/apb_master_arb_if.sv
// Bundle of the two requester channels and the APB completer bus.
// The master modport is the arbiter's view; the slave modport is the
// environment's view (requesters plus the APB completer).
interface apb_master_arb_if;
    logic        m0_req_valid;
    logic        m0_req_ready;
    logic        m0_req_write;
    logic [31:0] m0_req_addr;
    logic [31:0] m0_req_wdata;
    logic        m0_rsp_valid;
    logic [31:0] m0_rsp_rdata;
    logic        m0_rsp_err;

    logic        m1_req_valid;
    logic        m1_req_ready;
    logic        m1_req_write;
    logic [31:0] m1_req_addr;
    logic [31:0] m1_req_wdata;
    logic        m1_rsp_valid;
    logic [31:0] m1_rsp_rdata;
    logic        m1_rsp_err;

    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        input  m0_req_valid, m0_req_write, m0_req_addr, m0_req_wdata,
        output m0_req_ready, m0_rsp_valid, m0_rsp_rdata, m0_rsp_err,
        input  m1_req_valid, m1_req_write, m1_req_addr, m1_req_wdata,
        output m1_req_ready, m1_rsp_valid, m1_rsp_rdata, m1_rsp_err,
        output PADDR, PWRITE, PWDATA, PSEL, PENABLE,
        input  PRDATA, PREADY
    );

    modport slave (
        output m0_req_valid, m0_req_write, m0_req_addr, m0_req_wdata,
        input  m0_req_ready, m0_rsp_valid, m0_rsp_rdata, m0_rsp_err,
        output m1_req_valid, m1_req_write, m1_req_addr, m1_req_wdata,
        input  m1_req_ready, m1_rsp_valid, m1_rsp_rdata, m1_rsp_err,
        input  PADDR, PWRITE, PWDATA, PSEL, PENABLE,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_master_arb.sv
// Two-requester round-robin arbiter driving one APB completer.
//
// Handshakes: a request transfers on the rising edge where req_valid and
// req_ready are both high; the requester holds valid and its request fields
// stable until that edge. req_ready is only ever high in IDLE. A response is
// a single-cycle rsp_valid pulse with no back-pressure; rsp_rdata/rsp_err
// hold until the next response to the same requester.
module apb_master_arb #(
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_master_arb_if.master    bus,
    output logic [1:0]          fsm_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_t          state;
    logic            ptr;       // requester favoured when both are valid
    logic            grant;     // requester owning the current transfer
    logic [CW-1:0]   wait_cnt;
    logic            ready0;
    logic            ready1;
    logic            timeout_hit;
    logic            done;
    logic [31:0]     done_rdata;
    logic            done_err;

    // Grant selection: only in IDLE and out of reset; pointer breaks ties.
    always_comb begin
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (PRESET && state == IDLE) begin
            if (bus.m0_req_valid && (!bus.m1_req_valid || !ptr)) begin
                ready0 = 1'b1;
            end else if (bus.m1_req_valid) begin
                ready1 = 1'b1;
            end
        end
    end

    // Completion of an ACCESS phase: PREADY takes precedence over timeout.
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT));
        done        = (state == ACCESS) && (bus.PREADY || timeout_hit);
        done_err    = !bus.PREADY;
        done_rdata  = (bus.PREADY && !bus.PWRITE) ? bus.PRDATA : 32'h0;
    end

    assign bus.m0_req_ready = ready0;
    assign bus.m1_req_ready = ready1;
    assign fsm_state        = state;

    // Main FSM with registered APB and response outputs.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state            <= IDLE;
            ptr              <= 1'b0;
            grant            <= 1'b0;
            wait_cnt         <= '0;
            bus.PSEL         <= 1'b0;
            bus.PENABLE      <= 1'b0;
            bus.PWRITE       <= 1'b0;
            bus.PADDR        <= 32'h0;
            bus.PWDATA       <= 32'h0;
            bus.m0_rsp_valid <= 1'b0;
            bus.m0_rsp_rdata <= 32'h0;
            bus.m0_rsp_err   <= 1'b0;
            bus.m1_rsp_valid <= 1'b0;
            bus.m1_rsp_rdata <= 32'h0;
            bus.m1_rsp_err   <= 1'b0;
        end else begin
            bus.m0_rsp_valid <= 1'b0;
            bus.m1_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (ready0) begin
                        bus.PADDR  <= bus.m0_req_addr;
                        bus.PWRITE <= bus.m0_req_write;
                        bus.PWDATA <= bus.m0_req_wdata;
                        bus.PSEL   <= 1'b1;
                        grant      <= 1'b0;
                        ptr        <= 1'b1;
                        state      <= SETUP;
                    end else if (ready1) begin
                        bus.PADDR  <= bus.m1_req_addr;
                        bus.PWRITE <= bus.m1_req_write;
                        bus.PWDATA <= bus.m1_req_wdata;
                        bus.PSEL   <= 1'b1;
                        grant      <= 1'b1;
                        ptr        <= 1'b0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    bus.PENABLE <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        bus.PSEL    <= 1'b0;
                        bus.PENABLE <= 1'b0;
                        state       <= IDLE;
                        if (grant) begin
                            bus.m1_rsp_valid <= 1'b1;
                            bus.m1_rsp_rdata <= done_rdata;
                            bus.m1_rsp_err   <= done_err;
                        end else begin
                            bus.m0_rsp_valid <= 1'b1;
                            bus.m0_rsp_rdata <= done_rdata;
                            bus.m0_rsp_err   <= done_err;
                        end
                    end else if (TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    bus.PSEL    <= 1'b0;
                    bus.PENABLE <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb with a 16-word APB RAM model.
module tb_apb_master_arb;
    logic       PCLK;
    logic       PRESET;
    logic [1:0] fsm_state;

    apb_master_arb_if bus ();

    apb_master_arb #(.TIMEOUT(16)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Completer model controls
    logic [31:0] mem [16];
    int          acc_cnt;
    int          wait_states = 0;
    bit          never_ready = 1'b0;
    bit          stale_ready = 1'b0;

    // Clock
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Completer: RAM with programmable wait states, optional stale PREADY in SETUP
    always @(posedge PCLK) begin
        if (!PRESET) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[2]  <= 32'hDEADBEEF;
            acc_cnt <= 0;
        end else begin
            if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
            else acc_cnt <= 0;
            if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE)
                mem[bus.PADDR[5:2]] <= bus.PWDATA;
        end
    end

    assign bus.PREADY = (bus.PSEL && bus.PENABLE && !never_ready && acc_cnt == wait_states)
                      || (stale_ready && bus.PSEL && !bus.PENABLE);
    assign bus.PRDATA = mem[bus.PADDR[5:2]];

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_req(input int m, input logic v, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            bus.m0_req_valid = v; bus.m0_req_write = w;
            bus.m0_req_addr  = a; bus.m0_req_wdata = d;
        end else begin
            bus.m1_req_valid = v; bus.m1_req_write = w;
            bus.m1_req_addr  = a; bus.m1_req_wdata = d;
        end
    endtask

    function automatic logic ready_of(input int m);
        return (m == 0) ? bus.m0_req_ready : bus.m1_req_ready;
    endfunction

    function automatic logic [33:0] rsp_of(input int m);
        // {valid, err, rdata}
        return (m == 0) ? {bus.m0_rsp_valid, bus.m0_rsp_err, bus.m0_rsp_rdata}
                        : {bus.m1_rsp_valid, bus.m1_rsp_err, bus.m1_rsp_rdata};
    endfunction

    // Full transaction driver: returns response fields and accept-to-response latency
    task automatic do_txn(input int m, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rdata,
                          output logic err, output int lat);
        int cnt;
        logic [33:0] r;
        set_req(m, 1'b1, w, a, d);
        #1;
        cnt = 0;
        while (!ready_of(m) && cnt < 30) begin
            step(); #1; cnt++;
        end
        rdata = 32'h0; err = 1'b0; lat = -1;
        if (!ready_of(m)) begin
            n_checks++; n_fail++;
            $display("FAIL txn_accept_m%0d: ready=0 required=1", m);
            set_req(m, 1'b0, 1'b0, 32'h0, 32'h0);
            return;
        end
        step();
        set_req(m, 1'b0, 1'b0, 32'h0, 32'h0);
        lat = 1;
        r = rsp_of(m);
        while (!r[33] && lat < 40) begin
            step(); lat++;
            r = rsp_of(m);
        end
        if (!r[33]) begin
            n_checks++; n_fail++;
            $display("FAIL txn_rsp_m%0d: rsp_valid=0 required=1", m);
            lat = -1;
            return;
        end
        err   = r[32];
        rdata = r[31:0];
    endtask

    task automatic test_reset();
        logic [33:0] r0, r1;
        PRESET = 1'b0;
        set_req(0, 1'b1, 1'b1, 32'h1000_3000, 32'h1111_1111);
        set_req(1, 1'b1, 1'b1, 32'h1000_3004, 32'h2222_2222);
        bus.m0_req_valid = 1'b1;
        step(); step(); #1;
        n_checks++;
        if ({bus.m0_req_ready, bus.m1_req_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b required 00", {bus.m0_req_ready, bus.m1_req_ready});
        end
        n_checks++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000) begin
            n_fail++; $display("FAIL reset_apb_ctrl: got %b required 000", {bus.PSEL, bus.PENABLE, bus.PWRITE});
        end
        n_checks++;
        if ({bus.PADDR, bus.PWDATA} !== 64'h0) begin
            n_fail++; $display("FAIL reset_apb_data: got %h required 0", {bus.PADDR, bus.PWDATA});
        end
        r0 = rsp_of(0); r1 = rsp_of(1);
        n_checks++;
        if ({r0, r1} !== 68'h0) begin
            n_fail++; $display("FAIL reset_rsp: got %h required 0", {r0, r1});
        end
        n_checks++;
        if (fsm_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d required 0", fsm_state);
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        PRESET = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        logic [33:0] r;
        wait_states = 1;
        set_req(0, 1'b0, 1'b0, 32'h1000_3008, 32'h0);
        bus.m0_req_valid = 1'b1;
        #1;
        n_checks++;
        if ({bus.m0_req_ready, bus.m1_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL read_accept: got %b required 10", {bus.m0_req_ready, bus.m1_req_ready});
        end
        step(); // T+1
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if ({fsm_state, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR} !== {2'd1, 3'b100, 32'h1000_3008}) begin
            n_fail++; $display("FAIL read_setup: got st=%0d sel=%b en=%b addr=%h required st=1 sel=1 en=0 addr=10003008",
                               fsm_state, bus.PSEL, bus.PENABLE, bus.PADDR);
        end
        step(); // T+2
        n_checks++;
        if ({fsm_state, bus.PSEL, bus.PENABLE, bus.m0_rsp_valid} !== {2'd2, 3'b110}) begin
            n_fail++; $display("FAIL read_access: got st=%0d sel=%b en=%b rsp=%b required st=2 sel=1 en=1 rsp=0",
                               fsm_state, bus.PSEL, bus.PENABLE, bus.m0_rsp_valid);
        end
        step(); // T+3, wait state done, PREADY high
        n_checks++;
        if ({bus.PSEL, bus.PENABLE, bus.m0_rsp_valid} !== 3'b110) begin
            n_fail++; $display("FAIL read_wait: got sel=%b en=%b rsp=%b required 1 1 0",
                               bus.PSEL, bus.PENABLE, bus.m0_rsp_valid);
        end
        step(); // T+4
        r = rsp_of(0);
        n_checks++;
        if (r !== {2'b10, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL read_rsp: got %h required 2deadbeef", r);
        end
        n_checks++;
        if ({bus.PSEL, bus.PENABLE, bus.m1_rsp_valid} !== 3'b000) begin
            n_fail++; $display("FAIL read_end: got %b required 000", {bus.PSEL, bus.PENABLE, bus.m1_rsp_valid});
        end
        step(); // T+5: pulse gone, data held
        r = rsp_of(0);
        n_checks++;
        if (r !== {2'b00, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL read_hold: got %h required 0deadbeef", r);
        end
    endtask

    task automatic test_simultaneous();
        int k [2];
        int gm, cnt;
        logic [31:0] ea, ed;
        logic [33:0] r;
        wait_states = 0;
        k[0] = 0; k[1] = 0;
        PRESET = 1'b0;
        set_req(0, 1'b1, 1'b1, 32'h1000_3020, 32'hA000_0000);
        set_req(1, 1'b1, 1'b1, 32'h1000_3030, 32'hB000_0000);
        step();
        PRESET = 1'b1;
        for (int g = 0; g < 6; g++) begin
            #1;
            cnt = 0;
            while (!(bus.m0_req_ready || bus.m1_req_ready) && cnt < 10) begin
                step(); #1; cnt++;
            end
            n_checks++;
            if ({bus.m0_req_ready, bus.m1_req_ready} !== ((g % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL rr_grant_%0d: got %b required %b", g,
                                   {bus.m0_req_ready, bus.m1_req_ready}, (g % 2 == 0) ? 2'b10 : 2'b01);
            end
            gm = bus.m1_req_ready ? 1 : 0;
            ea = ((gm == 0) ? 32'h1000_3020 : 32'h1000_3030) + 32'(4 * k[gm]);
            ed = ((gm == 0) ? 32'hA000_0000 : 32'hB000_0000) + 32'(k[gm]);
            step(); // SETUP
            k[gm]++;
            if (k[gm] < 3)
                set_req(gm, 1'b1, 1'b1,
                        ((gm == 0) ? 32'h1000_3020 : 32'h1000_3030) + 32'(4 * k[gm]),
                        ((gm == 0) ? 32'hA000_0000 : 32'hB000_0000) + 32'(k[gm]));
            else
                set_req(gm, 1'b0, 1'b0, 32'h0, 32'h0);
            n_checks++;
            if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA} !== {3'b101, ea, ed}) begin
                n_fail++; $display("FAIL rr_setup_%0d: got ctl=%b addr=%h data=%h required ctl=101 addr=%h data=%h",
                                   g, {bus.PSEL, bus.PENABLE, bus.PWRITE}, bus.PADDR, bus.PWDATA, ea, ed);
            end
            step(); // ACCESS
            n_checks++;
            if ({bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWDATA} !== {2'b11, ea, ed}) begin
                n_fail++; $display("FAIL rr_access_%0d: got ctl=%b addr=%h data=%h required ctl=11 addr=%h data=%h",
                                   g, {bus.PSEL, bus.PENABLE}, bus.PADDR, bus.PWDATA, ea, ed);
            end
            step(); // response cycle, also the next accept cycle
            r = rsp_of(gm);
            n_checks++;
            if (r !== {2'b10, 32'h0}) begin
                n_fail++; $display("FAIL rr_rsp_%0d: got %h required 200000000", g, r);
            end
        end
    endtask

    task automatic test_write_readback();
        logic [31:0] rd;
        logic        er;
        int          lat;
        wait_states = 0;
        do_txn(1, 1'b1, 32'h1000_3004, 32'h1234_5678, rd, er, lat);
        n_checks++;
        if ({er, rd, lat} !== {1'b0, 32'h0, 32'd3}) begin
            n_fail++; $display("FAIL wr_rsp: got err=%b rdata=%h lat=%0d required err=0 rdata=0 lat=3", er, rd, lat);
        end
        do_txn(0, 1'b0, 32'h1000_3004, 32'h0, rd, er, lat);
        n_checks++;
        if ({er, rd} !== {1'b0, 32'h1234_5678}) begin
            n_fail++; $display("FAIL readback: got err=%b rdata=%h required err=0 rdata=12345678", er, rd);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        logic        er;
        int          lat;
        never_ready = 1'b1;
        do_txn(0, 1'b0, 32'h1000_3008, 32'h0, rd, er, lat);
        n_checks++;
        if ({er, rd, lat} !== {1'b1, 32'h0, 32'd19}) begin
            n_fail++; $display("FAIL timeout_rsp: got err=%b rdata=%h lat=%0d required err=1 rdata=0 lat=19", er, rd, lat);
        end
        n_checks++;
        if ({bus.PSEL, bus.PENABLE} !== 2'b00) begin
            n_fail++; $display("FAIL timeout_release: got %b required 00", {bus.PSEL, bus.PENABLE});
        end
        never_ready = 1'b0;
        do_txn(0, 1'b0, 32'h1000_3004, 32'h0, rd, er, lat);
        n_checks++;
        if ({er, rd, lat} !== {1'b0, 32'h1234_5678, 32'd3}) begin
            n_fail++; $display("FAIL after_timeout: got err=%b rdata=%h lat=%0d required err=0 rdata=12345678 lat=3", er, rd, lat);
        end
    endtask

    task automatic test_reset_in_access();
        bit seen;
        int cnt;
        logic [33:0] r;
        wait_states = 5;
        // Pointer is at m1 here because the previous grant went to m0.
        set_req(0, 1'b1, 1'b0, 32'h1000_3008, 32'h0);
        #1;
        step();
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        n_checks++;
        if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin
            n_fail++; $display("FAIL rst_pre_access: got %b required 11", {bus.PSEL, bus.PENABLE});
        end
        PRESET = 1'b0;
        step();
        PRESET = 1'b1;
        n_checks++;
        if ({fsm_state, bus.PSEL, bus.PENABLE} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_drop: got st=%0d sel=%b en=%b required 0 0 0", fsm_state, bus.PSEL, bus.PENABLE);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.m0_rsp_valid || bus.m1_rsp_valid) seen = 1'b1;
            step();
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL rst_no_rsp: got rsp=%b required 0", seen);
        end
        set_req(0, 1'b1, 1'b0, 32'h1000_3008, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h1000_3000, 32'h0);
        #1;
        n_checks++;
        if ({bus.m0_req_ready, bus.m1_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL rst_ptr: got %b required 10", {bus.m0_req_ready, bus.m1_req_ready});
        end
        step();
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        cnt = 0;
        while (!bus.m0_rsp_valid && cnt < 20) begin
            step(); cnt++;
        end
        r = rsp_of(0);
        n_checks++;
        if (r !== {2'b10, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL rst_after_rsp: got %h required 2deadbeef", r);
        end
        #1;
        n_checks++;
        if (bus.m1_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rsp_and_accept: got ready=%b required 1", bus.m1_req_ready);
        end
        step();
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        cnt = 0;
        while (!bus.m1_rsp_valid && cnt < 20) begin
            step(); cnt++;
        end
        r = rsp_of(1);
        n_checks++;
        if (r !== {2'b10, 32'h0}) begin
            n_fail++; $display("FAIL rst_m1_rsp: got %h required 200000000", r);
        end
    endtask

    task automatic test_stale_pready();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [33:0] r;
        wait_states = 0;
        stale_ready = 1'b1;
        set_req(1, 1'b1, 1'b1, 32'h1000_300C, 32'h55AA_55AA);
        #1;
        n_checks++;
        if (bus.m1_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL stale_accept: got %b required 1", bus.m1_req_ready);
        end
        step(); // SETUP with PREADY already high
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if ({fsm_state, bus.PSEL, bus.PENABLE} !== {2'd1, 2'b10}) begin
            n_fail++; $display("FAIL stale_setup: got st=%0d sel=%b en=%b required st=1 sel=1 en=0",
                               fsm_state, bus.PSEL, bus.PENABLE);
        end
        step(); // ACCESS
        n_checks++;
        if ({fsm_state, bus.PSEL, bus.PENABLE, bus.m1_rsp_valid} !== {2'd2, 3'b110}) begin
            n_fail++; $display("FAIL stale_access: got st=%0d sel=%b en=%b rsp=%b required st=2 1 1 0",
                               fsm_state, bus.PSEL, bus.PENABLE, bus.m1_rsp_valid);
        end
        step();
        r = rsp_of(1);
        n_checks++;
        if ({fsm_state, r} !== {2'd0, 2'b10, 32'h0}) begin
            n_fail++; $display("FAIL stale_rsp: got st=%0d rsp=%h required st=0 rsp=200000000", fsm_state, r);
        end
        stale_ready = 1'b0;
        do_txn(0, 1'b0, 32'h1000_300C, 32'h0, rd, er, lat);
        n_checks++;
        if ({er, rd} !== {1'b0, 32'h55AA_55AA}) begin
            n_fail++; $display("FAIL stale_readback: got err=%b rdata=%h required err=0 rdata=55aa55aa", er, rd);
        end
    endtask

    initial begin
        PRESET = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write_readback();
        test_timeout();
        test_reset_in_access();
        test_stale_pready();
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
